// File: rtl/rr_arbiter4_pkg.sv
// Shared types and constants for the four-requester round-robin arbiter.
// Also provides a one-hot decode helper that the arbiter and its checkers use.
package rr_arbiter4_pkg;

  localparam int N_REQ = 4;
  localparam int IDX_W = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  // Result of a rotating search: whether any bit was found, and where.
  typedef struct packed {
    logic             hit;
    logic [IDX_W-1:0] idx;
  } pick_t;

  function automatic logic [N_REQ-1:0] idx_to_onehot(input logic [IDX_W-1:0] idx);
    logic [N_REQ-1:0] oh;
    oh      = {N_REQ{1'b0}};
    oh[idx] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/encoder4to2.sv
// Existing 4-to-2 one-hot encoder: returns the index of the set bit.
// Any input that is not exactly one-hot (including all zeros) maps to 2'b00.
module encoder4to2 (
  input  logic [3:0] onehot,
  output logic [1:0] idx
);

  // One-hot to binary lookup.
  always_comb begin
    case (onehot)
      4'b0001: idx = 2'b00;
      4'b0010: idx = 2'b01;
      4'b0100: idx = 2'b10;
      4'b1000: idx = 2'b11;
      default: idx = 2'b00;
    endcase
  end

endmodule

// File: rtl/rr_arbiter4.sv
// Four-requester round-robin arbiter with registered one-hot grant and an
// optional hold limit that forces rotation while other requesters wait.
module rr_arbiter4
  import rr_arbiter4_pkg::*;
#(
  parameter int MAX_HOLD = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_valid
);

  localparam int HW = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);
  // Top count value: the forced-handover point, or all ones when unlimited.
  localparam logic [HW-1:0] HOLD_LAST = (MAX_HOLD == 0) ? {HW{1'b1}} : HW'(MAX_HOLD - 1);

  // First set bit of pool searching start, start+1, ... with 2-bit wrap.
  function automatic pick_t rr_pick(input logic [N_REQ-1:0] pool,
                                    input logic [IDX_W-1:0] start);
    pick_t            p;
    logic [IDX_W-1:0] cand;
    p.hit = 1'b0;
    p.idx = start;
    for (int i = 0; i < N_REQ; i++) begin
      cand = start + IDX_W'(i);
      if (pool[cand] && !p.hit) begin
        p.hit = 1'b1;
        p.idx = cand;
      end
    end
    return p;
  endfunction

  state_t           state_r;
  logic [IDX_W-1:0] owner_r;
  logic [IDX_W-1:0] ptr_r;
  logic [HW-1:0]    hold_cnt_r;
  logic [N_REQ-1:0] gnt_r;
  logic             gnt_valid_r;

  logic [N_REQ-1:0] others_s;
  pick_t            idle_pick_s;
  pick_t            next_pick_s;
  logic             owner_req_s;
  logic             hold_expired_s;
  logic [HW-1:0]    hold_inc_s;
  logic             take_s;
  logic [IDX_W-1:0] take_idx_s;
  logic             drop_s;

  assign others_s       = req & ~idx_to_onehot(owner_r);
  assign idle_pick_s    = rr_pick(req, ptr_r);
  assign next_pick_s    = rr_pick(others_s, owner_r + 2'd1);
  assign owner_req_s    = req[owner_r];
  assign hold_expired_s = (MAX_HOLD != 0) && (hold_cnt_r == HOLD_LAST);
  assign hold_inc_s     = (hold_cnt_r == HOLD_LAST) ? hold_cnt_r : hold_cnt_r + {{(HW-1){1'b0}}, 1'b1};

  // Decide whether this edge makes a new grant, drops to idle, or keeps the owner.
  always_comb begin
    take_s     = 1'b0;
    take_idx_s = 2'b00;
    drop_s     = 1'b0;
    case (state_r)
      IDLE: begin
        if (idle_pick_s.hit) begin
          take_s     = 1'b1;
          take_idx_s = idle_pick_s.idx;
        end else begin
          take_s = 1'b0;
        end
      end
      GRANT: begin
        if (!owner_req_s) begin
          if (next_pick_s.hit) begin
            take_s     = 1'b1;
            take_idx_s = next_pick_s.idx;
          end else begin
            drop_s = 1'b1;
          end
        end else if ((others_s != 4'b0000) && hold_expired_s) begin
          take_s     = 1'b1;
          take_idx_s = next_pick_s.idx;
        end else begin
          take_s = 1'b0;
        end
      end
      default: begin
        drop_s = 1'b1;
      end
    endcase
  end

  // Arbiter state machine with registered grant outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      owner_r     <= 2'b00;
      ptr_r       <= 2'b00;
      hold_cnt_r  <= {HW{1'b0}};
      gnt_r       <= 4'b0000;
      gnt_valid_r <= 1'b0;
    end else if (take_s) begin
      state_r     <= GRANT;
      owner_r     <= take_idx_s;
      ptr_r       <= take_idx_s + 2'd1;
      hold_cnt_r  <= {HW{1'b0}};
      gnt_r       <= idx_to_onehot(take_idx_s);
      gnt_valid_r <= 1'b1;
    end else if (drop_s) begin
      state_r     <= IDLE;
      hold_cnt_r  <= {HW{1'b0}};
      gnt_r       <= 4'b0000;
      gnt_valid_r <= 1'b0;
    end else if (state_r == GRANT) begin
      hold_cnt_r  <= hold_inc_s;
    end else begin
      hold_cnt_r  <= hold_cnt_r;
    end
  end

  encoder4to2 u_enc (
    .onehot (gnt_r),
    .idx    (gnt_idx)
  );

  assign gnt       = gnt_r;
  assign gnt_valid = gnt_valid_r;

endmodule
